// File: rtl/usb_ep_pkg.sv
// Shared type definitions for the USB endpoint arbiter: token types,
// handshake IDs, data PIDs and the arbiter FSM states.
// Optional build macro used by the arbiter: USB_EP_STALL_EN.
package usb_ep_pkg;

    typedef enum logic [1:0] {
        TOK_OUT   = 2'd0,
        TOK_IN    = 2'd1,
        TOK_SETUP = 2'd2
    } tok_type_e;

    typedef enum logic [1:0] {
        HS_ACK   = 2'd0,
        HS_NAK   = 2'd1,
        HS_STALL = 2'd2
    } hs_id_e;

    typedef enum logic [1:0] {
        PID_DATA0 = 2'd0,
        PID_DATA1 = 2'd1
    } data_pid_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_DATA = 3'd1,
        ST_RX_RESP = 3'd2,
        ST_TX_DATA = 3'd3,
        ST_TX_WAIT = 3'd4
    } state_e;

endpackage

// File: rtl/usb_ep_arbiter_if.sv
// Bus bundle between the USB packet engine / endpoint FIFOs and the
// endpoint arbiter. Signal suffixes are from the arbiter's point of view.
// With USB_EP_STALL_EN defined the bundle carries the per-endpoint halt vector.
interface usb_ep_arbiter_if #(parameter int EP_CNT = 4);

    // token decoder
    logic              tokValid_i;
    logic [1:0]        tokType_i;
    logic [3:0]        tokEp_i;
    // OUT/SETUP data receiver
    logic              rxDataValid_i;
    logic [7:0]        rxData_i;
    logic              rxPid_i;
    logic              rxDone_i;
    logic              rxOk_i;
    // IN data transmitter
    logic              txPop_i;
    logic [7:0]        txData_o;
    logic              txAvail_o;
    logic              txDone_i;
    logic              hostAck_i;
    logic              ackTimeout_i;
    // response request to the packet engine
    logic              respValid_o;
    logic              respHandshake_o;
    logic [1:0]        respPacketID_o;
    // OUT FIFOs
    logic [EP_CNT-1:0] fillDone_o;
    logic [EP_CNT-1:0] fillOk_o;
    logic [EP_CNT-1:0] fillValid_o;
    logic [7:0]        fillData_o;
    logic [EP_CNT-1:0] full_i;
    // IN FIFOs
    logic [EP_CNT-1:0] popDone_o;
    logic [EP_CNT-1:0] popOk_o;
    logic [EP_CNT-1:0] pop_o;
    logic [EP_CNT-1:0] avail_i;
    logic [7:0]        data_i [EP_CNT];
`ifdef USB_EP_STALL_EN
    logic [EP_CNT-1:0] epHalt_i;
`endif

    // arbiter side
    modport slave (
`ifdef USB_EP_STALL_EN
        input  epHalt_i,
`endif
        input  tokValid_i, tokType_i, tokEp_i,
        input  rxDataValid_i, rxData_i, rxPid_i, rxDone_i, rxOk_i,
        input  txPop_i, txDone_i, hostAck_i, ackTimeout_i,
        input  full_i, avail_i, data_i,
        output txData_o, txAvail_o,
        output respValid_o, respHandshake_o, respPacketID_o,
        output fillDone_o, fillOk_o, fillValid_o, fillData_o,
        output popDone_o, popOk_o, pop_o
    );

    // packet engine / FIFO side
    modport master (
`ifdef USB_EP_STALL_EN
        output epHalt_i,
`endif
        output tokValid_i, tokType_i, tokEp_i,
        output rxDataValid_i, rxData_i, rxPid_i, rxDone_i, rxOk_i,
        output txPop_i, txDone_i, hostAck_i, ackTimeout_i,
        output full_i, avail_i, data_i,
        input  txData_o, txAvail_o,
        input  respValid_o, respHandshake_o, respPacketID_o,
        input  fillDone_o, fillOk_o, fillValid_o, fillData_o,
        input  popDone_o, popOk_o, pop_o
    );

endinterface

// File: rtl/usb_ep_arbiter.sv
// USB device endpoint arbiter: routes OUT/SETUP payload into per-endpoint
// OUT FIFOs, streams IN payload from per-endpoint IN FIFOs, tracks the
// DATA0/DATA1 toggles and requests the matching handshake/data PID.
// Optional: USB_EP_STALL_EN adds epHalt_i; a halted endpoint answers STALL.
module usb_ep_arbiter
    import usb_ep_pkg::*;
#(
    parameter int EP_CNT = 4
) (
    input  logic              clk48_i,
    input  logic              rst_i,
    usb_ep_arbiter_if.slave   bus
);

    localparam int EPW = (EP_CNT > 1) ? $clog2(EP_CNT) : 1;

    state_e            state_q, state_d;
    logic [EPW-1:0]    ep_q, ep_d;
    tok_type_e         type_q, type_d;
    logic              dropped_q, dropped_d;
    logic [EP_CNT-1:0] tog_out_q, tog_out_d;
    logic [EP_CNT-1:0] tog_in_q, tog_in_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_hs_q, resp_hs_d;
    logic [1:0]        resp_id_q, resp_id_d;
    logic [EP_CNT-1:0] fill_done_q, fill_done_d;
    logic [EP_CNT-1:0] fill_ok_q, fill_ok_d;
    logic [EP_CNT-1:0] pop_done_q, pop_done_d;
    logic [EP_CNT-1:0] pop_ok_q, pop_ok_d;

    logic              tok_ep_ok;
    logic              tok_type_ok;
    logic [EPW-1:0]    tok_ep;
    logic              ep_halted;
    logic              byte_full;
    logic              drop_now;
    logic              pkt_ok;
    logic              rx_fwd;
    logic              tx_active;
    logic [EP_CNT-1:0] fill_valid_w;
    logic [EP_CNT-1:0] pop_w;

    // token qualification: endpoint in range and a known token type
    assign tok_ep_ok   = ({1'b0, bus.tokEp_i} < 5'(EP_CNT));
    assign tok_type_ok = (bus.tokType_i == TOK_OUT) || (bus.tokType_i == TOK_IN) ||
                         (bus.tokType_i == TOK_SETUP);
    assign tok_ep      = bus.tokEp_i[EPW-1:0];

`ifdef USB_EP_STALL_EN
    assign ep_halted = bus.epHalt_i[tok_ep];
`else
    assign ep_halted = 1'b0;
`endif

    // a packet is dropped as soon as any byte meets a full FIFO; the drop is
    // sticky so later bytes of the same packet never reach the FIFO either
    assign byte_full = bus.rxDataValid_i & bus.full_i[ep_q];
    assign drop_now  = dropped_q | byte_full;
    assign pkt_ok    = bus.rxOk_i & ~drop_now & (bus.rxPid_i == tog_out_q[ep_q]);
    assign rx_fwd    = (state_q == ST_RX_DATA) & bus.rxDataValid_i &
                       ~bus.full_i[ep_q] & ~dropped_q;
    assign tx_active = (state_q == ST_TX_DATA);

    // per-endpoint strobe fan-out, only the latched endpoint sees traffic
    for (genvar gi = 0; gi < EP_CNT; gi++) begin : g_ep
        assign fill_valid_w[gi] = rx_fwd && (ep_q == EPW'(gi));
        assign pop_w[gi]        = tx_active && bus.txPop_i && (ep_q == EPW'(gi));
    end

    assign bus.fillValid_o     = fill_valid_w;
    assign bus.fillData_o      = bus.rxData_i;
    assign bus.pop_o           = pop_w;
    assign bus.txData_o        = tx_active ? bus.data_i[ep_q] : 8'h00;
    assign bus.txAvail_o       = tx_active & bus.avail_i[ep_q];
    assign bus.respValid_o     = resp_valid_q;
    assign bus.respHandshake_o = resp_hs_q;
    assign bus.respPacketID_o  = resp_id_q;
    assign bus.fillDone_o      = fill_done_q;
    assign bus.fillOk_o        = fill_ok_q;
    assign bus.popDone_o       = pop_done_q;
    assign bus.popOk_o         = pop_ok_q;

    // next-state, toggle bookkeeping and one-cycle pulse requests
    always_comb begin
        state_d      = state_q;
        ep_d         = ep_q;
        type_d       = type_q;
        dropped_d    = dropped_q;
        tog_out_d    = tog_out_q;
        tog_in_d     = tog_in_q;
        resp_valid_d = 1'b0;
        resp_hs_d    = 1'b0;
        resp_id_d    = 2'd0;
        fill_done_d  = '0;
        fill_ok_d    = '0;
        pop_done_d   = '0;
        pop_ok_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.tokValid_i && tok_ep_ok && tok_type_ok) begin
                    if (ep_halted) begin
                        resp_valid_d = 1'b1;
                        resp_hs_d    = 1'b1;
                        resp_id_d    = 2'(HS_STALL);
                    end else if (bus.tokType_i == TOK_IN) begin
                        ep_d   = tok_ep;
                        type_d = TOK_IN;
                        if (bus.avail_i[tok_ep]) begin
                            // DATAx request goes out as we enter TX_DATA
                            state_d      = ST_TX_DATA;
                            resp_valid_d = 1'b1;
                            resp_id_d    = tog_in_q[tok_ep] ? 2'(PID_DATA1) : 2'(PID_DATA0);
                        end else begin
                            resp_valid_d = 1'b1;
                            resp_hs_d    = 1'b1;
                            resp_id_d    = 2'(HS_NAK);
                        end
                    end else begin
                        ep_d      = tok_ep;
                        type_d    = tok_type_e'(bus.tokType_i);
                        dropped_d = 1'b0;
                        state_d   = ST_RX_DATA;
                    end
                end
            end

            ST_RX_DATA: begin
                if (byte_full) begin
                    dropped_d = 1'b1;
                end
                if (bus.rxDone_i) begin
                    fill_done_d[ep_q] = 1'b1;
                    fill_ok_d[ep_q]   = pkt_ok;
                    // a bad CRC gets no handshake; a toggle mismatch is still ACKed
                    if (bus.rxOk_i) begin
                        resp_valid_d = 1'b1;
                        resp_hs_d    = 1'b1;
                        resp_id_d    = drop_now ? 2'(HS_NAK) : 2'(HS_ACK);
                    end
                    if ((type_q == TOK_OUT) && pkt_ok) begin
                        tog_out_d[ep_q] = ~tog_out_q[ep_q];
                    end
                    // an accepted SETUP restarts both directions at DATA1
                    if ((type_q == TOK_SETUP) && bus.rxOk_i && !drop_now) begin
                        tog_out_d[ep_q] = 1'b1;
                        tog_in_d[ep_q]  = 1'b1;
                    end
                    state_d = ST_RX_RESP;
                end
            end

            ST_RX_RESP: begin
                state_d = ST_IDLE;
            end

            ST_TX_DATA: begin
                if (bus.txDone_i) begin
                    state_d = ST_TX_WAIT;
                end
            end

            ST_TX_WAIT: begin
                // hostAck wins when both arrive in the same cycle
                if (bus.hostAck_i) begin
                    pop_done_d[ep_q] = 1'b1;
                    pop_ok_d[ep_q]   = 1'b1;
                    tog_in_d[ep_q]   = ~tog_in_q[ep_q];
                    state_d          = ST_IDLE;
                end else if (bus.ackTimeout_i) begin
                    pop_done_d[ep_q] = 1'b1;
                    state_d          = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and pulse registers; reset abandons any packet in flight
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ep_q         <= '0;
            type_q       <= TOK_OUT;
            dropped_q    <= 1'b0;
            tog_out_q    <= '0;
            tog_in_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_hs_q    <= 1'b0;
            resp_id_q    <= 2'd0;
            fill_done_q  <= '0;
            fill_ok_q    <= '0;
            pop_done_q   <= '0;
            pop_ok_q     <= '0;
        end else begin
            state_q      <= state_d;
            ep_q         <= ep_d;
            type_q       <= type_d;
            dropped_q    <= dropped_d;
            tog_out_q    <= tog_out_d;
            tog_in_q     <= tog_in_d;
            resp_valid_q <= resp_valid_d;
            resp_hs_q    <= resp_hs_d;
            resp_id_q    <= resp_id_d;
            fill_done_q  <= fill_done_d;
            fill_ok_q    <= fill_ok_d;
            pop_done_q   <= pop_done_d;
            pop_ok_q     <= pop_ok_d;
        end
    end

endmodule

// File: tb/tb_usb_ep_arbiter.sv
// Self-checking bench for usb_ep_arbiter: transaction-level model of the
// endpoint toggles and expected per-cycle outputs, random traffic, plus
// directed scenarios with literal expectations.
// Build with USB_EP_STALL_EN defined to also exercise the halt/STALL path.
module tb_usb_ep_arbiter;
    import usb_ep_pkg::*;

    localparam int EP_CNT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_ep_arbiter_if #(.EP_CNT(EP_CNT)) bus();

    usb_ep_arbiter #(.EP_CNT(EP_CNT)) dut (
        .clk48_i (clk),
        .rst_i   (rst),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // model state
    bit [EP_CNT-1:0] tog_out, tog_in, halt_v;

    // expected registered outputs for the current cycle and for the next one
    logic              e_resp_valid, e_resp_hs, n_resp_valid, n_resp_hs;
    logic [1:0]        e_resp_id, n_resp_id;
    logic [EP_CNT-1:0] e_fill_done, e_fill_ok, e_pop_done, e_pop_ok;
    logic [EP_CNT-1:0] n_fill_done, n_fill_ok, n_pop_done, n_pop_ok;
    // expected combinational outputs for the current cycle
    logic [EP_CNT-1:0] e_fill_valid, e_pop;
    logic [7:0]        e_tx_data, e_fill_data;
    logic              e_tx_avail;

    // observations gathered by the compare process
    int cap_fill_cnt, cap_pop_cnt, cap_resp_cnt;
    logic cap_resp_hs;
    logic [1:0] cap_resp_id;
    logic [EP_CNT-1:0] cap_fill_done, cap_fill_ok, cap_pop_done, cap_pop_ok;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, got, want);
        end
    endtask

    task automatic clear_caps();
        cap_fill_cnt = 0; cap_pop_cnt = 0; cap_resp_cnt = 0;
        cap_resp_hs = 1'b0; cap_resp_id = 2'd0;
        cap_fill_done = '0; cap_fill_ok = '0; cap_pop_done = '0; cap_pop_ok = '0;
    endtask

    // one compare per output per cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("respValid", 32'(bus.respValid_o), 32'(e_resp_valid));
            if (e_resp_valid) begin
                cmp("respHandshake", 32'(bus.respHandshake_o), 32'(e_resp_hs));
                cmp("respPacketID", 32'(bus.respPacketID_o), 32'(e_resp_id));
            end
            cmp("fillDone", 32'(bus.fillDone_o), 32'(e_fill_done));
            cmp("fillOk", 32'(bus.fillOk_o), 32'(e_fill_ok));
            cmp("popDone", 32'(bus.popDone_o), 32'(e_pop_done));
            cmp("popOk", 32'(bus.popOk_o), 32'(e_pop_ok));
            cmp("fillValid", 32'(bus.fillValid_o), 32'(e_fill_valid));
            cmp("fillData", 32'(bus.fillData_o), 32'(e_fill_data));
            cmp("pop", 32'(bus.pop_o), 32'(e_pop));
            cmp("txData", 32'(bus.txData_o), 32'(e_tx_data));
            cmp("txAvail", 32'(bus.txAvail_o), 32'(e_tx_avail));
            if (bus.respValid_o) begin
                cap_resp_cnt++;
                cap_resp_hs = bus.respHandshake_o;
                cap_resp_id = bus.respPacketID_o;
            end
            cap_fill_cnt += $countones(bus.fillValid_o);
            cap_pop_cnt  += $countones(bus.pop_o);
            cap_fill_done |= bus.fillDone_o;
            cap_fill_ok   |= bus.fillOk_o;
            cap_pop_done  |= bus.popDone_o;
            cap_pop_ok    |= bus.popOk_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e_resp_valid = n_resp_valid; e_resp_hs = n_resp_hs; e_resp_id = n_resp_id;
        e_fill_done = n_fill_done; e_fill_ok = n_fill_ok;
        e_pop_done = n_pop_done; e_pop_ok = n_pop_ok;
        n_resp_valid = 1'b0; n_resp_hs = 1'b0; n_resp_id = 2'd0;
        n_fill_done = '0; n_fill_ok = '0; n_pop_done = '0; n_pop_ok = '0;
    endtask

    // background inputs; junk=1 adds stray strobes that must be ignored
    task automatic drive_idle(input bit junk);
        bus.tokValid_i    = 1'b0;
        bus.tokType_i     = 2'($urandom);
        bus.tokEp_i       = 4'($urandom);
        bus.rxDataValid_i = junk ? 1'($urandom) : 1'b0;
        bus.rxData_i      = 8'($urandom);
        bus.rxPid_i       = 1'($urandom);
        bus.rxDone_i      = junk ? 1'($urandom) : 1'b0;
        bus.rxOk_i        = 1'($urandom);
        bus.txPop_i       = 1'($urandom);
        bus.txDone_i      = junk ? 1'($urandom) : 1'b0;
        bus.hostAck_i     = junk ? 1'($urandom) : 1'b0;
        bus.ackTimeout_i  = junk ? 1'($urandom) : 1'b0;
        bus.full_i        = EP_CNT'($urandom);
        bus.avail_i       = EP_CNT'($urandom);
        for (int e = 0; e < EP_CNT; e++) bus.data_i[e] = 8'($urandom);
`ifdef USB_EP_STALL_EN
        bus.epHalt_i      = halt_v;
`endif
        e_fill_valid = '0; e_pop = '0; e_tx_data = 8'h00; e_tx_avail = 1'b0;
        e_fill_data  = bus.rxData_i;
    endtask

    task automatic stall_tail(input int ep, output bit stalled);
        stalled = 1'b0;
`ifdef USB_EP_STALL_EN
        if (halt_v[ep]) begin
            n_resp_valid = 1'b1; n_resp_hs = 1'b1; n_resp_id = 2'd2;
            tick(); drive_idle(1); tick();
            stalled = 1'b1;
        end
`endif
    endtask

    // OUT (typ 0) or SETUP (typ 2) transaction; full_at<0 means never full
    task automatic do_out(input int ep, input int typ, input bit pid, input int n,
                          input int full_at, input bit crc);
        bit drop = 1'b0;
        bit ok;
        bit stalled;
        drive_idle(0);
        bus.tokValid_i = 1'b1; bus.tokType_i = 2'(typ); bus.tokEp_i = 4'(ep);
        if (ep >= EP_CNT || typ == 3) begin
            tick(); drive_idle(1); tick();
            return;
        end
        stall_tail(ep, stalled);
        if (stalled) return;
        tick();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin drive_idle(0); tick(); end
            drive_idle(0);
            bus.rxDataValid_i = 1'b1;
            bus.full_i[ep] = (i == full_at);
            e_fill_valid[ep] = !drop && !bus.full_i[ep];
            drop = drop | bus.full_i[ep];
            tick();
        end
        drive_idle(0);
        bus.rxDone_i = 1'b1; bus.rxOk_i = crc; bus.rxPid_i = pid;
        ok = crc && !drop && (pid == tog_out[ep]);
        n_fill_done[ep] = 1'b1; n_fill_ok[ep] = ok;
        if (crc) begin
            n_resp_valid = 1'b1; n_resp_hs = 1'b1; n_resp_id = drop ? 2'd1 : 2'd0;
        end
        if (typ == 0 && ok) tog_out[ep] = !tog_out[ep];
        if (typ == 2 && crc && !drop) begin tog_out[ep] = 1'b1; tog_in[ep] = 1'b1; end
        tick();
        drive_idle(1); tick();
    endtask

    // IN transaction; outcome 0=hostAck, 1=ackTimeout, 2=both together
    task automatic do_in(input int ep, input bit avail, input int n, input int outcome,
                         input bit always_pop);
        bit stalled;
        drive_idle(0);
        bus.tokValid_i = 1'b1; bus.tokType_i = 2'd1; bus.tokEp_i = 4'(ep);
        if (ep >= EP_CNT) begin
            tick(); drive_idle(1); tick();
            return;
        end
        bus.avail_i[ep] = avail;
        stall_tail(ep, stalled);
        if (stalled) return;
        if (!avail) begin
            n_resp_valid = 1'b1; n_resp_hs = 1'b1; n_resp_id = 2'd1;
            tick(); drive_idle(1); tick();
            return;
        end
        n_resp_valid = 1'b1; n_resp_hs = 1'b0; n_resp_id = {1'b0, tog_in[ep]};
        tick();
        for (int i = 0; i <= n; i++) begin
            drive_idle(0);
            if (i == n) begin
                bus.txDone_i = 1'b1;
                bus.txPop_i = always_pop ? 1'b0 : 1'($urandom);
            end else begin
                bus.txPop_i = always_pop ? 1'b1 : 1'($urandom);
            end
            e_pop[ep] = bus.txPop_i;
            e_tx_data = bus.data_i[ep];
            e_tx_avail = bus.avail_i[ep];
            tick();
        end
        for (int w = $urandom_range(2); w > 0; w--) begin drive_idle(0); tick(); end
        drive_idle(0);
        bus.hostAck_i = (outcome != 1);
        bus.ackTimeout_i = (outcome != 0);
        n_pop_done[ep] = 1'b1; n_pop_ok[ep] = (outcome != 1);
        if (outcome != 1) tog_in[ep] = !tog_in[ep];
        tick();
        drive_idle(1); tick();
    endtask

    initial begin
        tog_out = '0; tog_in = '0; halt_v = '0;
        n_resp_valid = 1'b0; n_resp_hs = 1'b0; n_resp_id = 2'd0;
        n_fill_done = '0; n_fill_ok = '0; n_pop_done = '0; n_pop_ok = '0;
        clear_caps();

        // reset: everything quiet
        rst = 1'b1;
        drive_idle(0);
        tick();
        chk_en = 1'b1;
        drive_idle(1); tick();
        drive_idle(1); tick();
        rst = 1'b0;
        cmp("reset_respValid", 32'(bus.respValid_o), 32'd0);
        cmp("reset_fillDone", 32'(bus.fillDone_o), 32'd0);

        // OUT ep1 DATA0, 8 bytes, good CRC
        clear_caps();
        do_out(1, 0, 1'b0, 8, -1, 1'b1);
        cmp("out1_fill_cnt", 32'(cap_fill_cnt), 32'd8);
        cmp("out1_fill_ok", 32'(cap_fill_ok), 32'h2);
        cmp("out1_resp", 32'({cap_resp_hs, cap_resp_id}), 32'h4);
        cmp("out1_model_tog", 32'(tog_out[1]), 32'd1);

        // same DATA0 again: ACKed, discarded, toggle kept
        clear_caps();
        do_out(1, 0, 1'b0, 8, -1, 1'b1);
        cmp("out1_rep_done", 32'(cap_fill_done), 32'h2);
        cmp("out1_rep_ok", 32'(cap_fill_ok), 32'h0);
        cmp("out1_rep_resp", 32'({cap_resp_hs, cap_resp_id}), 32'h4);
        cmp("out1_rep_model_tog", 32'(tog_out[1]), 32'd1);

        // OUT ep2 hitting a full FIFO at byte 3
        clear_caps();
        do_out(2, 0, 1'b0, 8, 3, 1'b1);
        cmp("out2_full_cnt", 32'(cap_fill_cnt), 32'd3);
        cmp("out2_full_ok", 32'(cap_fill_ok), 32'h0);
        cmp("out2_full_resp", 32'({cap_resp_hs, cap_resp_id}), 32'h5);

        // IN ep0 empty -> NAK, then 4 bytes ACKed
        clear_caps();
        do_in(0, 1'b0, 0, 0, 1'b1);
        cmp("in0_nak", 32'({cap_resp_hs, cap_resp_id}), 32'h5);
        clear_caps();
        do_in(0, 1'b1, 4, 0, 1'b1);
        cmp("in0_data_pid", 32'({cap_resp_hs, cap_resp_id}), 32'h0);
        cmp("in0_pop_cnt", 32'(cap_pop_cnt), 32'd4);
        cmp("in0_pop_ok", 32'(cap_pop_ok), 32'h1);
        cmp("in0_model_tog", 32'(tog_in[0]), 32'd1);

        // IN ep0 timeout -> rollback, toggle unchanged
        clear_caps();
        do_in(0, 1'b1, 2, 1, 1'b1);
        cmp("in0_to_pid", 32'({cap_resp_hs, cap_resp_id}), 32'h1);
        cmp("in0_to_done", 32'(cap_pop_done), 32'h1);
        cmp("in0_to_ok", 32'(cap_pop_ok), 32'h0);
        cmp("in0_to_model_tog", 32'(tog_in[0]), 32'd1);

        // out-of-range endpoint is ignored
        clear_caps();
        do_in(7, 1'b1, 2, 0, 1'b1);
        cmp("ep7_no_resp", 32'(cap_resp_cnt), 32'd0);

        // reset in the middle of an OUT packet
        clear_caps();
        drive_idle(0);
        bus.tokValid_i = 1'b1; bus.tokType_i = 2'd0; bus.tokEp_i = 4'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_idle(0);
            bus.rxDataValid_i = 1'b1; bus.full_i[1] = 1'b0;
            e_fill_valid[1] = 1'b1;
            tick();
        end
        drive_idle(0);
        rst = 1'b1;
        tog_out = '0; tog_in = '0;
        tick();
        rst = 1'b0;
        drive_idle(1); tick();
        cmp("midrst_no_done", 32'(cap_fill_done), 32'h0);
        clear_caps();
        do_out(1, 0, 1'b0, 2, -1, 1'b1);
        cmp("midrst_tog_cleared", 32'(cap_fill_ok), 32'h2);

        // SETUP ep3 then OUT DATA1 is accepted, IN starts at DATA1
        clear_caps();
        do_out(3, 2, 1'b0, 8, -1, 1'b1);
        do_out(3, 0, 1'b1, 3, -1, 1'b1);
        cmp("setup_out_ok", 32'(cap_fill_ok), 32'h8);
        clear_caps();
        do_in(3, 1'b1, 1, 2, 1'b0);
        cmp("setup_in_pid", 32'({cap_resp_hs, cap_resp_id}), 32'h1);
        cmp("both_ack_ok", 32'(cap_pop_ok), 32'h8);

`ifdef USB_EP_STALL_EN
        clear_caps();
        halt_v = 4'b1000;
        do_in(3, 1'b1, 4, 0, 1'b1);
        cmp("stall_resp", 32'({cap_resp_hs, cap_resp_id}), 32'h6);
        cmp("stall_no_pop", 32'(cap_pop_cnt), 32'd0);
        halt_v = '0;
`endif

        // random traffic against the model
        for (int k = 0; k < 250; k++) begin
            int r;
            int ep;
`ifdef USB_EP_STALL_EN
            for (int e = 0; e < EP_CNT; e++) halt_v[e] = ($urandom_range(7) == 0);
`endif
            r  = $urandom_range(9);
            ep = $urandom_range(EP_CNT - 1);
            if (r <= 3)
                do_out(ep, ($urandom_range(3) == 0) ? 2 : 0, 1'($urandom), $urandom_range(6),
                       ($urandom_range(3) == 0) ? $urandom_range(5) : -1, $urandom_range(4) != 0);
            else if (r <= 6)
                do_in(ep, $urandom_range(4) != 0, $urandom_range(5), $urandom_range(2), 1'b0);
            else if (r == 7)
                do_out($urandom_range(15, EP_CNT), 0, 1'b0, 2, -1, 1'b1);
            else if (r == 8)
                do_out(ep, 3, 1'b0, 2, -1, 1'b1);
            else begin
                drive_idle(1); tick();
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
